// File: rtl/turbo_pkg.sv
// Shared constants, types and modular helpers for the LTE QPP turbo interleaver.
package turbo_pkg;

    localparam int K_LARGE  = 6144;
    localparam int K_SMALL  = 1056;
    localparam int F1_LARGE = 263;
    localparam int F2_LARGE = 480;
    localparam int F1_SMALL = 17;
    localparam int F2_SMALL = 66;

    typedef logic [12:0]      idx_t;
    typedef logic [7:0][12:0] lanes_t;
    typedef enum logic {LOAD, SEND} state_t;

    // Lane j starts at PI(j); the tables fold to constants at elaboration.
    function automatic lanes_t p0_table(input int f1, input int f2, input int k);
        lanes_t t;
        for (int j = 0; j < 8; j++) t[j] = idx_t'((f1 * j + f2 * j * j) % k);
        return t;
    endfunction

    function automatic lanes_t d0_table(input int f1, input int f2, input int k);
        lanes_t t;
        for (int j = 0; j < 8; j++) t[j] = idx_t'((8 * f1 + f2 * (16 * j + 64)) % k);
        return t;
    endfunction

    localparam lanes_t P0_LARGE   = p0_table(F1_LARGE, F2_LARGE, K_LARGE);
    localparam lanes_t D0_LARGE   = d0_table(F1_LARGE, F2_LARGE, K_LARGE);
    localparam idx_t   STEP_LARGE = idx_t'((128 * F2_LARGE) % K_LARGE);
    localparam lanes_t P0_SMALL   = p0_table(F1_SMALL, F2_SMALL, K_SMALL);
    localparam lanes_t D0_SMALL   = d0_table(F1_SMALL, F2_SMALL, K_SMALL);
    localparam idx_t   STEP_SMALL = idx_t'((128 * F2_SMALL) % K_SMALL);

    // (a + b) mod k for a, b < k, arranged so no intermediate exceeds 13 bits.
    function automatic idx_t mod_add(input idx_t a, input idx_t b, input idx_t k);
        idx_t gap;
        gap = k - b;
        return (a >= gap) ? (a - gap) : (a + b);
    endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Eight-lane QPP index generator: lane j holds PI(8m+j) for the next output byte.
// Latency: indices update one edge after start/step. Backpressure: holds when step is low.
// TURBO_SMALL_BLOCK_EN enables the K=1056 tables selected by k_sel.
module qpp_addr_gen
    import turbo_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    input  logic   step,
    input  logic   k_sel,
    output lanes_t idx
);

    lanes_t d_q;
    lanes_t p_init;
    lanes_t d_init;
    idx_t   k_mod;
    idx_t   d_inc;

`ifdef TURBO_SMALL_BLOCK_EN
    always_comb begin
        k_mod  = k_sel ? idx_t'(K_LARGE) : idx_t'(K_SMALL);
        d_inc  = k_sel ? STEP_LARGE : STEP_SMALL;
        p_init = k_sel ? P0_LARGE : P0_SMALL;
        d_init = k_sel ? D0_LARGE : D0_SMALL;
    end
`else
    logic unused_k_sel;
    assign unused_k_sel = k_sel;
    always_comb begin
        k_mod  = idx_t'(K_LARGE);
        d_inc  = STEP_LARGE;
        p_init = P0_LARGE;
        d_init = D0_LARGE;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx <= '0;
            d_q <= '0;
        end else if (start) begin
            idx <= p_init;
            d_q <= d_init;
        end else if (step) begin
            for (int j = 0; j < 8; j++) begin
                idx[j] <= mod_add(idx[j], d_q[j], k_mod);
                d_q[j] <= mod_add(d_q[j], d_inc, k_mod);
            end
        end
    end

endmodule

// File: rtl/turbo_interleaver.sv
// LTE QPP turbo interleaver: buffers one K-bit block of bytes, then emits it permuted.
// Latency: first output byte valid the edge after the last input byte. Backpressure: rdy_out=0 holds data_out.
// TURBO_SMALL_BLOCK_EN makes cbs select K=1056; otherwise K=6144 always.
module turbo_interleaver
    import turbo_pkg::*;
#(
    parameter int KMAX = 6144,
    parameter int BW   = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vld_crc,
    input  logic          rdy_out,
    input  logic          cbs,
    input  logic [BW-1:0] data_in,
    output logic          rdy_crc,
    output logic          vld_out,
    output logic          last_byte,
    output logic [BW-1:0] data_out
);

    localparam int CW = $clog2(KMAX / 8);
    typedef logic [CW-1:0] cnt_t;

    state_t          state;
    cnt_t            in_cnt;
    cnt_t            out_cnt;
    cnt_t            last_idx;
    logic            k_large;
    logic            k_sel;
    logic [KMAX-1:0] bit_mem;
    lanes_t          idx;
    logic [7:0]      rev_in;
    logic [7:0]      gather;
    logic            acc_in, acc_out, in_done, out_done, gen_start, gen_step;

    assign acc_in    = (state == LOAD) && rdy_crc && vld_crc;
    assign acc_out   = (state == SEND) && vld_out && rdy_out;
    assign last_idx  = k_large ? cnt_t'(K_LARGE / 8 - 1) : cnt_t'(K_SMALL / 8 - 1);
    assign in_done   = acc_in && (in_cnt == last_idx);
    assign out_done  = acc_out && (out_cnt == last_idx);
    assign gen_start = acc_in && (in_cnt == '0);
    assign gen_step  = in_done || (acc_out && !out_done);

`ifdef TURBO_SMALL_BLOCK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         k_large <= 1'b1;
        else if (gen_start) k_large <= cbs;
    end
    assign k_sel = gen_start ? cbs : k_large;
`else
    logic unused_cbs;
    assign unused_cbs = cbs;
    assign k_large    = 1'b1;
    assign k_sel      = 1'b1;
`endif

    qpp_addr_gen u_addr_gen (
        .clk   (clk),
        .reset (reset),
        .start (gen_start),
        .step  (gen_step),
        .k_sel (k_sel),
        .idx   (idx)
    );

    // Byte 0 is fetched on the same edge the final input byte lands, so that byte is bypassed.
    always_comb begin
        rev_in = '0;
        gather = '0;
        for (int j = 0; j < 8; j++) begin
            rev_in[j] = data_in[7-j];
            if (acc_in && (idx[j][12:3] == in_cnt))
                gather[7-j] = data_in[~idx[j][2:0]];
            else
                gather[7-j] = bit_mem[idx[j]];
        end
    end

    always_ff @(posedge clk) begin
        if (acc_in) bit_mem[{in_cnt, 3'b000} +: 8] <= rev_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOAD;
            in_cnt    <= '0;
            out_cnt   <= '0;
            rdy_crc   <= 1'b0;
            vld_out   <= 1'b0;
            last_byte <= 1'b0;
            data_out  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    rdy_crc <= 1'b1;
                    if (in_done) begin
                        state     <= SEND;
                        in_cnt    <= '0;
                        out_cnt   <= '0;
                        rdy_crc   <= 1'b0;
                        vld_out   <= 1'b1;
                        last_byte <= 1'b0;
                        data_out  <= gather;
                    end else if (acc_in) begin
                        in_cnt <= in_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (out_done) begin
                        state     <= LOAD;
                        out_cnt   <= '0;
                        rdy_crc   <= 1'b1;
                        vld_out   <= 1'b0;
                        last_byte <= 1'b0;
                    end else if (acc_out) begin
                        out_cnt   <= out_cnt + 1'b1;
                        data_out  <= gather;
                        last_byte <= ((out_cnt + 1'b1) == last_idx);
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_interleaver.sv
// Directed bench for turbo_interleaver: reference QPP model built from the closed-form PI(i).
module tb_turbo_interleaver;

    logic       clk = 1'b0;
    logic       reset;
    logic       vld_crc;
    logic       rdy_out;
    logic       cbs;
    logic [7:0] data_in;
    logic       rdy_crc;
    logic       vld_out;
    logic       last_byte;
    logic [7:0] data_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] in_b  [768];
    logic [7:0] exp_b [768];
    logic [7:0] got   [768];

    always #5 clk = ~clk;

    turbo_interleaver dut (
        .clk       (clk),
        .reset     (reset),
        .vld_crc   (vld_crc),
        .rdy_out   (rdy_out),
        .cbs       (cbs),
        .data_in   (data_in),
        .rdy_crc   (rdy_crc),
        .vld_out   (vld_out),
        .last_byte (last_byte),
        .data_out  (data_out)
    );

    function automatic int pi(input int i, input int k);
        longint f1, f2, li;
        f1 = (k == 6144) ? 263 : 17;
        f2 = (k == 6144) ? 480 : 66;
        li = i;
        return int'((f1 * li + f2 * li * li) % k);
    endfunction

    function automatic void build_exp(input int nb, input int k);
        int p;
        for (int m = 0; m < nb; m++) begin
            for (int j = 0; j < 8; j++) begin
                p = pi(8 * m + j, k);
                exp_b[m][7-j] = in_b[p / 8][7 - (p % 8)];
            end
        end
    endfunction

    function automatic void clear_in();
        for (int n = 0; n < 768; n++) in_b[n] = 8'h00;
    endfunction

    task automatic send_block(input int nb, input logic cbs_v);
        int   n = 0;
        int   cyc = 0;
        logic acc;
        logic saw_vld = 1'b0;
        cbs = cbs_v;
        while (n < nb && cyc < nb + 50) begin
            @(negedge clk);
            cyc++;
            if (vld_out !== 1'b0) saw_vld = 1'b1;
            data_in = in_b[n];
            vld_crc = 1'b1;
            cbs     = (n > 0) ? ~cbs_v : cbs_v;
            acc     = rdy_crc;
            @(posedge clk);
            if (acc === 1'b1) n++;
        end
        checks++;
        if (n != nb) begin
            errors++;
            $display("FAIL send_count accepted=%0d expected=%0d", n, nb);
        end
        checks++;
        if (saw_vld) begin
            errors++;
            $display("FAIL load_vld_out vld_out went high during LOAD, expected 0");
        end
    endtask

    task automatic collect(input int nb, input int mode);
        int         cnt = 0;
        int         cyc = 0;
        logic       stall = 1'b0;
        logic [7:0] hd = 8'h00;
        while (cnt < nb && cyc < 4 * nb + 50) begin
            @(negedge clk);
            cyc++;
            rdy_out = (mode == 0) ? 1'b1 : ((cyc % 3) != 1);
            if (cyc == 1) begin
                checks++;
                if (vld_out !== 1'b1 || rdy_crc !== 1'b0) begin
                    errors++;
                    $display("FAIL first_out_latency vld_out=%b rdy_crc=%b expected 1/0", vld_out, rdy_crc);
                end
            end
            if (stall) begin
                checks++;
                if (vld_out !== 1'b1 || data_out !== hd) begin
                    errors++;
                    $display("FAIL stall_hold vld_out=%b data_out=%h expected 1/%h", vld_out, data_out, hd);
                end
            end
            stall = 1'b0;
            if (vld_out === 1'b1) begin
                if (rdy_out) begin
                    got[cnt] = data_out;
                    checks++;
                    if (data_out !== exp_b[cnt]) begin
                        errors++;
                        $display("FAIL data_byte[%0d] got=%h expected=%h", cnt, data_out, exp_b[cnt]);
                    end
                    checks++;
                    if (last_byte !== (cnt == nb - 1)) begin
                        errors++;
                        $display("FAIL last_byte[%0d] got=%b expected=%b", cnt, last_byte, (cnt == nb - 1));
                    end
                    cnt++;
                    if (cnt == nb) vld_crc = 1'b0;
                end else begin
                    stall = 1'b1;
                    hd    = data_out;
                end
            end
        end
        vld_crc = 1'b0;
        checks++;
        if (cnt != nb) begin
            errors++;
            $display("FAIL out_count got=%0d expected=%0d", cnt, nb);
        end
        @(negedge clk);
        checks++;
        if (vld_out !== 1'b0 || last_byte !== 1'b0) begin
            errors++;
            $display("FAIL after_last vld_out=%b last_byte=%b expected 0/0", vld_out, last_byte);
        end
        @(negedge clk);
        checks++;
        if (rdy_crc !== 1'b1) begin
            errors++;
            $display("FAIL reload_rdy rdy_crc=%b expected 1", rdy_crc);
        end
        rdy_out = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; vld_crc = 1'b0; rdy_out = 1'b1; cbs = 1'b1; data_in = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (rdy_crc !== 1'b0 || vld_out !== 1'b0 || last_byte !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_state rdy_crc=%b vld_out=%b last_byte=%b data_out=%h expected 0/0/0/00",
                     rdy_crc, vld_out, last_byte, data_out);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rdy_crc !== 1'b0) begin
            errors++;
            $display("FAIL rdy_before_edge rdy_crc=%b expected 0", rdy_crc);
        end
        @(negedge clk);
        checks++;
        if (rdy_crc !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_release rdy_crc=%b expected 1", rdy_crc);
        end
    endtask

    task automatic test_random_block(input int mode);
        for (int n = 0; n < 768; n++) in_b[n] = 8'($urandom);
        in_b[0] = 8'h54;
        build_exp(768, 6144);
        send_block(768, 1'b1);
        collect(768, mode);
    endtask

    task automatic test_single_bit(input int pos, input logic [7:0] want0);
        int nz = 0;
        clear_in();
        in_b[pos / 8][7 - (pos % 8)] = 1'b1;
        build_exp(768, 6144);
        send_block(768, 1'b1);
        collect(768, 0);
        checks++;
        if (got[0] !== want0) begin
            errors++;
            $display("FAIL single_bit_%0d byte0 got=%h expected=%h", pos, got[0], want0);
        end
        for (int m = 1; m < 768; m++) if (got[m] !== 8'h00) nz++;
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL single_bit_%0d nonzero_bytes got=%0d expected=0", pos, nz);
        end
    endtask

    task automatic test_small_block();
        clear_in();
        in_b[0]  = 8'h80;
        in_b[10] = 8'h10;
        in_b[37] = 8'h20;
`ifdef TURBO_SMALL_BLOCK_EN
        build_exp(132, 1056);
        send_block(132, 1'b0);
        collect(132, 0);
        checks++;
        if (got[0] !== 8'hE0) begin
            errors++;
            $display("FAIL small_byte0 got=%h expected=e0", got[0]);
        end
`else
        build_exp(768, 6144);
        send_block(768, 1'b0);
        collect(768, 0);
        checks++;
        if (got[0] !== 8'h80) begin
            errors++;
            $display("FAIL cbs_ignored_byte0 got=%h expected=80", got[0]);
        end
`endif
    endtask

    task automatic test_mid_reset();
        for (int n = 0; n < 768; n++) in_b[n] = 8'($urandom);
        send_block(300, 1'b1);
        @(negedge clk);
        reset   = 1'b0;
        vld_crc = 1'b0;
        cbs     = 1'b1;
        #1;
        checks++;
        if (rdy_crc !== 1'b0 || vld_out !== 1'b0 || last_byte !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_clear rdy_crc=%b vld_out=%b last_byte=%b data_out=%h expected 0/0/0/00",
                     rdy_crc, vld_out, last_byte, data_out);
        end
        @(negedge clk);
        reset = 1'b1;
        test_random_block(0);
    endtask

    initial begin
        test_reset();
        test_random_block(0);
        test_random_block(0);
        test_single_bit(743, 8'h40);
        test_single_bit(785, 8'h01);
        test_random_block(1);
        test_small_block();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
